popcount_window_detect: RTL
===========================

Name: popcount_window_detect

Overview:
- Parametrised, pipelined successor to the team's 4-input "2 or 3 inputs high" detector.
- Counts the high bits of a WIDTH-bit input vector and tests the count against a programmable window [lo, hi] in inside or outside mode.
- Also tracks matches: a saturating hit counter and a consecutive-match run detector.
- Sits on a valid-qualified sample stream inside the lab datapath; results feed status/LED logic.

Parameters:
- WIDTH, 4: input vector width, must be ≥1.
- CNT_W, derived clog2(WIDTH+1), local: width of the popcount and thresholds (3 for WIDTH=4).
- HITS_W, 8: hit counter width.
- RUN_LEN, 3: consecutive matching results needed to raise run_det, must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data, lo, hi and mode are valid this cycle.
- in_data  in  WIDTH  sample vector.
- lo  in  CNT_W  window lower bound, inclusive.
- hi  in  CNT_W  window upper bound, inclusive.
- mode  in  1  0 = match inside [lo,hi]; 1 = match outside.
- clr  in  1  clears hit_count, hit_sat and the run streak.
- out_valid  out  1  result valid, one pulse per accepted sample.
- out_match  out  1  window test result.
- out_count  out  CNT_W  popcount of the sample.
- hit_count  out  HITS_W  number of valid matching results.
- hit_sat  out  1  sticky; hit_count has saturated.
- run_det  out  1  RUN_LEN or more consecutive valid results matched.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs and internal registers go to 0. Any in-flight samples are dropped, with no out_valid for them.
- Stage 1, on in_valid=1: register popcount(in_data), lo, hi, mode and valid. Thresholds are sampled together with the data, so a threshold change applies from the sample accepted in the same cycle.
- Stage 2: out_valid <= stage-1 valid; out_count <= count.
  - mode=0: out_match <= (lo ≤ count ≤ hi).
  - mode=1: out_match <= the inverse of that.
- Latency is exactly 2 cycles from in_valid to out_valid. Throughput is 1 sample/cycle; there is no backpressure.
- When out_valid=0, out_match and out_count hold their last values.
- lo > hi means an empty window: match=0 in mode 0 and match=1 in mode 1.
- Full-width compares only, no overflow. Threshold values above WIDTH are legal and never equal a count.
- Defaults lo=2, hi=3, mode=0 with WIDTH=4 reproduce the original detector's truth table.
- Hit counter, sharing the out_valid cycle: if clr=1, then hit_count <= 0 and hit_sat <= 0.
  - clr wins over a simultaneous increment; that hit is lost.
  - Otherwise, on out_valid & out_match, hit_count increments.
  - At 2^HITS_W−1 the counter holds and hit_sat <= 1. hit_sat stays set until clr or reset.
- Run streak: an internal counter saturating at RUN_LEN.
  - A valid matching result increments it.
  - A valid non-matching result zeroes it.
  - Cycles with out_valid=0 leave it unchanged; gaps do not break a run.
  - run_det = (streak == RUN_LEN), registered; it updates in the cycle after the qualifying result.
  - clr zeroes the streak and run_det; clr takes priority.
- clr does not affect the data pipeline or out_valid.

Decomposition:
- Shared include (team constants header): a clog2 function; mode encodings MODE_INSIDE=0, MODE_OUTSIDE=1.
- Sub-module vec_popcount (parameter WIDTH): combinational popcount producing CNT_W bits. It is reused by future detectors.
- Top level holds the pipeline registers, comparator, hit counter and run streak.

Test Plan:
- Defaults (WIDTH=4, lo=2, hi=3, mode=0); stream all 16 vectors 0000..1111 back-to-back with in_valid=1 -> 16 out_valid pulses starting 2 cycles later. out_match=1 exactly for vectors with 2 or 3 ones. hit_count ends at 10.
- mode=1, lo=2, hi=3; input 1111 -> out_count=4, out_match=1. Input 0110 -> out_match=0. lo=3, hi=1, mode=0; any input -> out_match=0.
- HITS_W=2; 5 matching samples -> hit_count 1,2,3,3,3. hit_sat rises on the 3rd hit. clr then gives hit_count=0, hit_sat=0. clr in the same cycle as a hit -> hit_count=0.
- RUN_LEN=3; results match, match, gap, match -> run_det=1 the cycle after the 3rd match. A following non-match -> run_det=0.
- in_valid at cycle 0 and rst_n=0 at cycle 1 -> no out_valid ever appears for that sample; all outputs are 0 the cycle after reset.
- WIDTH=9, lo=9, hi=9; input all ones -> out_count=9, out_match=1. Input 0x1FE -> out_count=8, out_match=0.

Source files
------------

// File: rtl/popcount_window_detect_pkg.sv
// rtl/popcount_window_detect_pkg.sv - shared constants and helpers for the popcount window detector
package popcount_window_detect_pkg;

  typedef enum logic {
    MODE_INSIDE  = 1'b0,
    MODE_OUTSIDE = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_HITS_W  = 8;
  localparam int DEFAULT_RUN_LEN = 3;

  // Smallest r with 2**r >= value; used to size counts that must hold 0..N.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_window_detect_if.sv
// rtl/popcount_window_detect_if.sv - sample stream in, window result out
interface popcount_window_detect_if
  import popcount_window_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CNT_W = clog2(WIDTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] hi;
  logic             mode;

  logic             out_valid;
  logic             out_match;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, lo, hi, mode,
    input  out_valid, out_match, out_count
  );

  modport slave (
    input  in_valid, in_data, lo, hi, mode,
    output out_valid, out_match, out_count
  );

endinterface

// File: rtl/popcount_window_detect_vec_popcount.sv
// rtl/popcount_window_detect_vec_popcount.sv - combinational population count
module vec_popcount
  import popcount_window_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_window_detect.sv
// rtl/popcount_window_detect.sv - two-stage popcount window test with hit counter and run detector
module popcount_window_detect
  import popcount_window_detect_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int HITS_W  = DEFAULT_HITS_W,
  parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  popcount_window_detect_if.slave bus,
  output logic [HITS_W-1:0]     hit_count,
  output logic                  hit_sat,
  output logic                  run_det
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int RUN_W = clog2(RUN_LEN + 1);
  localparam logic [HITS_W-1:0] HITS_MAX   = '1;
  localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(RUN_LEN);

  logic [CNT_W-1:0] pop_count;

  logic             s1_valid_q;
  logic [CNT_W-1:0] s1_count_q;
  logic [CNT_W-1:0] s1_lo_q;
  logic [CNT_W-1:0] s1_hi_q;
  logic             s1_mode_q;

  logic             out_valid_q;
  logic             out_match_q;
  logic [CNT_W-1:0] out_count_q;

  logic             in_window;
  logic             match_d;

  logic [HITS_W-1:0] hit_count_q, hit_count_d;
  logic              hit_sat_q, hit_sat_d;
  logic [RUN_W-1:0]  streak_q, streak_d;
  logic              run_det_q, run_det_d;

  vec_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .data_i  (bus.in_data),
    .count_o (pop_count)
  );

  // Stage 1: thresholds travel with the sample they were presented with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_count_q <= '0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s1_mode_q  <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_count_q <= pop_count;
        s1_lo_q    <= bus.lo;
        s1_hi_q    <= bus.hi;
        s1_mode_q  <= bus.mode;
      end
    end
  end

  // lo > hi naturally yields an empty window here.
  always_comb begin
    in_window = (s1_lo_q <= s1_count_q) && (s1_count_q <= s1_hi_q);
    match_d   = (s1_mode_q == 1'(MODE_OUTSIDE)) ? !in_window : in_window;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_match_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_match_q <= match_d;
        out_count_q <= s1_count_q;
      end
    end
  end

  // Tracking logic runs off the registered result, so clr aligns with out_valid.
  always_comb begin
    hit_count_d = hit_count_q;
    hit_sat_d   = hit_sat_q;
    streak_d    = streak_q;
    if (clr) begin
      hit_count_d = '0;
      hit_sat_d   = 1'b0;
      streak_d    = '0;
    end else if (out_valid_q) begin
      if (out_match_q) begin
        if (hit_count_q != HITS_MAX) begin
          hit_count_d = hit_count_q + 1'b1;
        end
        if (hit_count_d == HITS_MAX) begin
          hit_sat_d = 1'b1;
        end
        if (streak_q != RUN_TARGET) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
    run_det_d = !clr && (streak_d == RUN_TARGET);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q <= '0;
      hit_sat_q   <= 1'b0;
      streak_q    <= '0;
      run_det_q   <= 1'b0;
    end else begin
      hit_count_q <= hit_count_d;
      hit_sat_q   <= hit_sat_d;
      streak_q    <= streak_d;
      run_det_q   <= run_det_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_match = out_match_q;
  assign bus.out_count = out_count_q;
  assign hit_count     = hit_count_q;
  assign hit_sat       = hit_sat_q;
  assign run_det       = run_det_q;

endmodule
